// File: rtl/colour_lookup.sv
`default_nettype none
// ============================================================================
// Module   : colour_lookup
// Purpose  : Per-pixel palette stage in front of a synchronous-read colour
//            ROM (2^ADDR_W x 12-bit RGB444). Each incoming field value is
//            right-shifted, saturated to the ROM address range and offset by
//            a per-frame animation phase to form the ROM address. The ROM
//            data is returned together with the video sidebands through a
//            two-stage valid/ready pipeline with full backpressure.
//
// Ports    : clk, rst_n                      clock, async active-low reset
//            in_valid / in_ready             upstream handshake
//            in_field                        scalar field value (FIELD_W)
//            in_sof                          first pixel of frame
//            in_de, in_hsync, in_vsync       input video sidebands
//            rom_en, rom_addr                ROM read request (registered addr)
//            rom_dout                        ROM data, one edge after request
//            out_valid / out_ready           downstream handshake
//            out_r, out_g, out_b             RGB444 colour (0 when blanked)
//            out_de, out_hsync, out_vsync    sidebands aligned with colour
//
// Revision : 1.0  initial release
// ============================================================================
module colour_lookup #(
   parameter int FIELD_W    = 16,
   parameter int SHIFT      = 4,
   parameter int ADDR_W     = 11,
   parameter int PHASE_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FIELD_W-1:0] in_field,
   input  logic              in_sof,
   input  logic              in_de,
   input  logic              in_hsync,
   input  logic              in_vsync,

   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_dout,

   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_r,
   output logic [3:0]        out_g,
   output logic [3:0]        out_b,
   output logic              out_de,
   output logic              out_hsync,
   output logic              out_vsync
);

   // Phase increment reduced to the address width; the phase accumulator
   // is intentionally modulo 2^ADDR_W.
   localparam logic [ADDR_W-1:0] c_PHASE_STEP = ADDR_W'(PHASE_STEP);

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   // Stage A: address register (rom_addr) plus beat qualifiers.
   logic              r_valid_a;
   logic              r_de_a;
   logic              r_hsync_a;
   logic              r_vsync_a;

   // Stage B: ROM output (held inside the ROM) plus beat qualifiers.
   logic              r_valid_b;
   logic              r_de_b;
   logic              r_hsync_b;
   logic              r_vsync_b;

   // Animation phase for the current frame.
   logic [ADDR_W-1:0] r_phase;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic              w_advance;
   logic              w_accept;

   // B can take a new beat when it is empty or being drained this cycle.
   // An empty B therefore always advances, collapsing bubbles even when the
   // downstream is not ready.
   assign w_advance = !r_valid_b || out_ready;

   // A can accept when it moves into B this cycle or is already empty.
   assign in_ready  = w_advance || !r_valid_a;
   assign w_accept  = in_valid && in_ready;

   // The ROM only reads when A's contents actually move into B, so its
   // output register holds its value throughout a stall.
   assign rom_en    = w_advance && r_valid_a;

   // ------------------------------------------------------------------------
   // Address generation
   // ------------------------------------------------------------------------
   logic [FIELD_W-1:0] w_shifted;
   logic [ADDR_W-1:0]  w_scaled;
   logic [ADDR_W-1:0]  w_ph_eff;
   logic [ADDR_W-1:0]  w_addr_next;

   assign w_shifted = in_field >> SHIFT;

   // Saturate only when the shifted field can exceed the address range;
   // otherwise it is simply zero-extended.
   generate
      if (FIELD_W > ADDR_W) begin : g_sat
         assign w_scaled = (|w_shifted[FIELD_W-1:ADDR_W]) ? {ADDR_W{1'b1}}
                                                         : w_shifted[ADDR_W-1:0];
      end else begin : g_nosat
         assign w_scaled = ADDR_W'(w_shifted);
      end
   endgenerate

   // The start-of-frame pixel already uses the new frame's phase.
   assign w_ph_eff    = in_sof ? (r_phase + c_PHASE_STEP) : r_phase;

   // Adding the phase after saturation wraps the top of the palette back to
   // the bottom; this is the animation effect, not an overflow bug.
   assign w_addr_next = w_scaled + w_ph_eff;

   // ------------------------------------------------------------------------
   // Phase accumulator: advances only on accepted start-of-frame beats.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
      end else if (w_accept && in_sof) begin
         r_phase <= w_ph_eff;
      end
   end

   // ------------------------------------------------------------------------
   // Stage A
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_a <= 1'b0;
         rom_addr  <= '0;
         r_de_a    <= 1'b0;
         r_hsync_a <= 1'b0;
         r_vsync_a <= 1'b0;
      end else if (w_accept) begin
         r_valid_a <= 1'b1;
         rom_addr  <= w_addr_next;
         r_de_a    <= in_de;
         r_hsync_a <= in_hsync;
         r_vsync_a <= in_vsync;
      end else if (w_advance) begin
         // Contents moved into B with nothing behind them.
         r_valid_a <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Stage B: the ROM captures its data on the same edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_b <= 1'b0;
         r_de_b    <= 1'b0;
         r_hsync_b <= 1'b0;
         r_vsync_b <= 1'b0;
      end else if (w_advance) begin
         r_valid_b <= r_valid_a;
         r_de_b    <= r_de_a;
         r_hsync_b <= r_hsync_a;
         r_vsync_b <= r_vsync_a;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   logic [11:0] w_colour;

   // Blanked or empty beats carry black so stale ROM data never leaks out.
   assign w_colour  = (r_valid_b && r_de_b) ? rom_dout : 12'h000;

   assign out_r     = w_colour[11:8];
   assign out_g     = w_colour[7:4];
   assign out_b     = w_colour[3:0];
   assign out_valid = r_valid_b;
   assign out_de    = r_de_b;
   assign out_hsync = r_hsync_b;
   assign out_vsync = r_vsync_b;

endmodule
`default_nettype wire

// File: tb/tb_colour_lookup.sv
`default_nettype none
// ============================================================================
// Module   : tb_colour_lookup
// Purpose  : Self-checking bench for colour_lookup with a behavioural
//            synchronous-read ROM whose contents are rom[a] = 3*a + 0x15A.
// Revision : 1.0  initial release
// ============================================================================
module tb_colour_lookup;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready;
   logic [15:0] in_field;
   logic        in_sof, in_de, in_hsync, in_vsync;
   logic        rom_en;
   logic [10:0] rom_addr;
   logic [11:0] rom_dout = 12'h000;
   logic        out_valid, out_ready;
   logic [3:0]  out_r, out_g, out_b;
   logic        out_de, out_hsync, out_vsync;
   logic [11:0] colour;

   int checks = 0;
   int errors = 0;

   assign colour = {out_r, out_g, out_b};

   colour_lookup #(
      .FIELD_W(16), .SHIFT(4), .ADDR_W(11), .PHASE_STEP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_field(in_field),
      .in_sof(in_sof), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_g(out_g), .out_b(out_b),
      .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_val(input logic [10:0] a);
      return 12'(32'(a) * 3 + 32'h15A);
   endfunction

   // Behavioural ROM: synchronous read, holds when not enabled.
   always @(posedge clk) if (rom_en) rom_dout <= rom_val(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_field = 16'h0; in_sof = 1'b0;
      in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
   endtask

   // Ends one ns after a rising edge with reset released.
   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [15:0] field;
      logic        sof, de, hs, vs;
      logic [10:0] addr;
      logic [11:0] col;
   } vec_t;

   vec_t tbl[9];

   initial begin
      idle_inputs();
      out_ready = 1'b1;
      do_reset();

      // Reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rom_en",    rom_en,    0);
      chk("rst_colour",    colour,    0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_rom_addr",  rom_addr,  0);
      chk("rst_sidebands", {out_de, out_hsync, out_vsync}, 0);

      // Single-beat vectors, phase starts at 0 and is carried across rows.
      //          field     sof   de    hs    vs    addr     colour
      tbl[0] = '{16'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 11'd256,  12'h45A};
      tbl[1] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 11'd2047, 12'h957};
      tbl[2] = '{16'h1000, 1'b0, 1'b0, 1'b1, 1'b1, 11'd256,  12'h000};
      tbl[3] = '{16'h0010, 1'b1, 1'b1, 1'b0, 1'b1, 11'd2,    12'h160};
      tbl[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0,    12'h15A};
      tbl[5] = '{16'h7FF0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd1,    12'h15D};
      tbl[6] = '{16'h0800, 1'b0, 1'b1, 1'b0, 1'b0, 11'd130,  12'h2E0};
      tbl[7] = '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 11'd1,    12'h15D};
      tbl[8] = '{16'h7FEF, 1'b0, 1'b1, 1'b1, 1'b1, 11'd0,    12'h15A};

      foreach (tbl[i]) begin
         in_valid = 1'b1; in_field = tbl[i].field; in_sof = tbl[i].sof;
         in_de = tbl[i].de; in_hsync = tbl[i].hs; in_vsync = tbl[i].vs;
         @(posedge clk); #1;
         idle_inputs();
         chk($sformatf("vec%0d_addr", i), rom_addr, tbl[i].addr);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_colour", i), colour, tbl[i].col);
         chk($sformatf("vec%0d_sb", i), {out_de, out_hsync, out_vsync},
             {tbl[i].de, tbl[i].hs, tbl[i].vs});
      end

      // Phase accumulation and wrap: 2000 sof beats, then scaled 100.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         in_valid = 1'b1; in_sof = 1'b1; in_field = 16'h0; in_de = 1'b1;
         @(posedge clk); #1;
      end
      chk("phase_last_sof_addr", rom_addr, 2000);
      in_sof = 1'b0; in_field = 16'h0640;
      @(posedge clk); #1;
      idle_inputs();
      chk("phase_wrap_addr", rom_addr, 52);
      @(posedge clk); #1;
      chk("phase_wrap_colour", colour, 12'h1F6);

      // Backpressure: addresses 0..9, out_ready low in cycles 3..6.
      do_reset();
      begin
         int sent = 0;
         int got = 0;
         logic [11:0] held = '0;
         logic stalled_prev = 1'b0;
         for (int c = 0; c < 60 && got < 10; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 10);
            in_field  = 16'(sent << 4);
            in_de     = 1'b1;
            in_sof    = 1'b0;
            #3;
            if (c >= 3 && c <= 6) begin
               chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
               chk($sformatf("bp_rom_en_c%0d", c), rom_en, 0);
            end
            if (stalled_prev) chk($sformatf("bp_hold_c%0d", c), colour, held);
            if (out_valid && out_ready) begin
               chk($sformatf("bp_beat%0d", got), colour, rom_val(11'(got)));
               got++;
            end
            stalled_prev = out_valid && !out_ready;
            held = colour;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
         end
         chk("bp_beat_count", got, 10);
      end
      idle_inputs();
      out_ready = 1'b1;

      // Asynchronous reset mid-stream.
      do_reset();
      in_valid = 1'b1; in_sof = 1'b1; in_field = 16'h1000; in_de = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      chk("areset_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_rom_en",    rom_en,    0);
      chk("areset_in_ready",  in_ready,  1);
      idle_inputs();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_field = 16'h1000; in_de = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      chk("areset_phase0_addr", rom_addr, 256);
      @(posedge clk); #1;
      chk("areset_colour", colour, 12'h45A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/colour_lookup.md
# colour_lookup

Per-pixel palette stage sitting directly upstream of the `rom` colour table (2048 × 12-bit RGB444). Accepts a stream of scalar field values from the lava renderer with video sidebands. Scales and saturates each field value and adds a per-frame animation phase to form the ROM address. Drives the ROM's synchronous read and emits the RGB444 colour, sideband-aligned, through a valid/ready handshake with full backpressure.

## Interface
- `FIELD_W`, 16: width of incoming field value
- `SHIFT`, 4: right shift applied to field before saturation
- `ADDR_W`, 11: ROM address width (2048 entries)
- `PHASE_STEP`, 1: phase increment per frame, mod 2^ADDR_W
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: upstream beat valid
- `in_ready` out 1: stage can accept beat
- `in_field` in FIELD_W: scalar field value
- `in_sof` in 1: first pixel of frame
- `in_de`, `in_hsync`, `in_vsync` in 1 each: video sidebands
- `rom_en` out 1: ROM read enable
- `rom_addr` out ADDR_W: ROM address (registered)
- `rom_dout` in 12: ROM data, valid one edge after `rom_en`/`rom_addr` sampled
- `out_valid` out 1: output beat valid
- `out_ready` in 1: downstream accepts
- `out_r`, `out_g`, `out_b` out 4 each: RGB444 colour
- `out_de`, `out_hsync`, `out_vsync` out 1 each: aligned sidebands

## Operation
- Two stages. A: registered `rom_addr` plus `valid_a` and sidebands. B: ROM output plus `valid_b` and sidebands.
- `advance = !valid_b || out_ready`. `rom_en = advance && valid_a`. `in_ready = advance || !valid_a`.
- Accept (`in_valid && in_ready`) loads A. If A is not reloaded and `advance`, clear `valid_a`.
- On `advance`, B loads `valid_a` and A's sidebands. ROM updates `rom_dout` the same edge.
- While stalled (`!advance`), A, B, `rom_en=0` and `rom_dout` all hold.
- Address: `scaled = min(in_field >> SHIFT, 2^ADDR_W-1)`.
- `ph_eff = in_sof ? phase+PHASE_STEP : phase`, mod 2^ADDR_W.
- `rom_addr <= (scaled + ph_eff) mod 2^ADDR_W`. Wrap after saturation is intentional.
- `phase <= ph_eff` on every accepted beat with `in_sof=1`. Non-accepted sof beats do not advance phase.
- Colour: `{out_r,out_g,out_b} = (valid_b && de_b) ? rom_dout : 12'h000`. `out_valid = valid_b`.
- Blanked beats (`in_de=0`) still pass through the pipeline and consume a ROM read.

## Timing
- Reset (async assert, sync-safe deassert): `valid_a=valid_b=0`, `rom_addr=0`, `phase=0`, sidebands 0.
- Reset consequences: `out_valid=0`, `rom_en=0`, colour outputs 0, `in_ready=1`.
- Latency: beat accepted at edge k appears on `out_*` after edge k+1, with no stall.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Backpressure: with `out_ready=0` and both stages full, `in_ready=0`. Outputs stable until the handshake.
- Empty B with `out_ready=0` still advances (bubble collapse).
- Reset mid-stream: in-flight beats are dropped and `phase` returns to 0.
- Simultaneous accept into A and drain of B is the normal full-rate case. No beat is lost or duplicated.

## Test plan
- Basic lookup: reset, phase 0, `in_field=16'h1000`, de=1 → `rom_addr=256`. One edge later `out_valid=1`, colour = ROM[256].
- Saturation: `in_field=16'hFFFF` → `rom_addr=2047`. Colour = ROM[2047], last `colour.data` line.
- Phase and wrap: 2000 sof beats (phase=2000), then field `16'h0640` (scaled 100) → `rom_addr=52`.
- Blanking: `in_de=0`, field `16'h1000` → `out_valid=1`, `out_de=0`, RGB 0, hsync/vsync match input two edges later.
- Backpressure: stream addrs 0..9, `out_ready` low cycles 3–6 → `in_ready` drops after 2 beats buffered. Outputs 0..9 in order, none lost/duplicated, colour stable while stalled.
- Async reset: assert `rst_n=0` mid-stream between edges → `out_valid`, `rom_en` fall immediately. After release, `phase=0` and first beat maps with phase 0.
